// File: rtl/store_write_buffer.sv
// Posted-store write buffer between the MEM stage and data memory.
// Stores are queued in a small FIFO and drained in the background. Loads
// that hit a buffered word are forwarded from the youngest matching entry.
// Load misses take the single memory port ahead of new drains.
module store_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          cpu_we,
  input  logic          cpu_re,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ready,
  input  logic [31:0]   mem_rdata,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, LOAD = 2'd2} state_t;

  state_t        state, state_next;
  logic [29:0]   ent_addr [DEPTH];
  logic [31:0]   ent_data [DEPTH];
  logic [PW-1:0] head, tail, head_plus, idx;
  logic [CW-1:0] count_next;
  logic          full, hit, load_hit, load_miss, enq, pop, match;
  logic [31:0]   hit_data;
  logic          mem_req_next, mem_we_next;
  logic [31:0]   mem_addr_next, mem_wdata_next;

  assign full       = (count == CW'(DEPTH));
  assign enq        = cpu_we & ~full;
  assign pop        = (state == DRAIN) & mem_ready;
  assign load_hit   = cpu_re & ~cpu_we & hit;
  assign load_miss  = cpu_re & ~cpu_we & ~hit;
  assign count_next = count + {{(CW-1){1'b0}}, enq} - {{(CW-1){1'b0}}, pop};
  assign head_plus  = head + {{(PW-1){1'b0}}, 1'b1};
  assign empty      = (count == {CW{1'b0}}) & (state == IDLE);

  // Search valid entries oldest to youngest so the youngest match wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = 32'd0;
    idx      = {PW{1'b0}};
    match    = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx      = head + PW'(k);
      match    = (CW'(k) < count) && (ent_addr[idx] == cpu_addr[31:2]);
      hit      = hit | match;
      hit_data = match ? ent_data[idx] : hit_data;
    end
  end

  // Stall and load-data return towards the pipeline.
  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = 32'd0;
    if (Reset) begin
      cpu_stall = 1'b0;
      cpu_rdata = 32'd0;
    end else begin
      cpu_stall = (cpu_we & full) |
                  (load_miss & ~((state == LOAD) & mem_ready));
      if (load_hit) begin
        cpu_rdata = hit_data;
      end else if ((state == LOAD) & mem_ready) begin
        cpu_rdata = mem_rdata;
      end else begin
        cpu_rdata = 32'd0;
      end
    end
  end

  // Next-state and next memory-request computation.
  always_comb begin
    state_next     = state;
    mem_req_next   = mem_req;
    mem_we_next    = mem_we;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    case (state)
      IDLE: begin
        if (load_miss) begin
          state_next     = LOAD;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = {cpu_addr[31:2], 2'b00};
          mem_wdata_next = 32'd0;
        end else if (count != {CW{1'b0}}) begin
          state_next     = DRAIN;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b1;
          mem_addr_next  = {ent_addr[head], 2'b00};
          mem_wdata_next = ent_data[head];
        end else begin
          state_next = IDLE;
        end
      end
      DRAIN: begin
        if (mem_ready) begin
          if (load_miss) begin
            state_next     = LOAD;
            mem_req_next   = 1'b1;
            mem_we_next    = 1'b0;
            mem_addr_next  = {cpu_addr[31:2], 2'b00};
            mem_wdata_next = 32'd0;
          end else if (count_next != {CW{1'b0}}) begin
            state_next   = DRAIN;
            mem_req_next = 1'b1;
            mem_we_next  = 1'b1;
            // With only the head left, the next head is the store arriving now.
            if (count > {{(CW-1){1'b0}}, 1'b1}) begin
              mem_addr_next  = {ent_addr[head_plus], 2'b00};
              mem_wdata_next = ent_data[head_plus];
            end else begin
              mem_addr_next  = {cpu_addr[31:2], 2'b00};
              mem_wdata_next = cpu_wdata;
            end
          end else begin
            state_next   = IDLE;
            mem_req_next = 1'b0;
            mem_we_next  = 1'b0;
          end
        end else begin
          state_next = DRAIN;
        end
      end
      LOAD: begin
        if (mem_ready) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
        end else begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
        mem_we_next  = 1'b0;
      end
    endcase
  end

  // State, FIFO storage, pointers and registered memory request.
  always_ff @(posedge clk) begin
    if (Reset) begin
      state     <= IDLE;
      head      <= {PW{1'b0}};
      tail      <= {PW{1'b0}};
      count     <= {CW{1'b0}};
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= 30'd0;
        ent_data[i] <= 32'd0;
      end
    end else begin
      state     <= state_next;
      count     <= count_next;
      mem_req   <= mem_req_next;
      mem_we    <= mem_we_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      if (enq) begin
        ent_addr[tail] <= cpu_addr[31:2];
        ent_data[tail] <= cpu_wdata;
        tail           <= tail + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        tail <= tail;
      end
      if (pop) begin
        head <= head_plus;
      end else begin
        head <= head;
      end
    end
  end

endmodule

// File: tb/tb_store_write_buffer.sv
// Directed bench for store_write_buffer with hand-computed expectations.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          Reset;
  logic          cpu_we, cpu_re;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          mem_req, mem_we, mem_ready;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          empty;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_err = 0;

  store_write_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .Reset(Reset),
    .cpu_we(cpu_we), .cpu_re(cpu_re), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .empty(empty), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Apply CPU-side inputs and let combinational outputs settle.
  task automatic drv(input logic we, input logic re, input logic [31:0] a, input logic [31:0] d);
    cpu_we    = we;
    cpu_re    = re;
    cpu_addr  = a;
    cpu_wdata = d;
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; mem_ready = 1'b0; mem_rdata = 32'd0;
    drv(1'b0, 1'b0, 32'd0, 32'd0);
    next(); next();
    Reset = 1'b0; #2;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_stall", 32'(cpu_stall), 32'd0);

    // Reset mid-DRAIN with three buffered stores.
    next(); drv(1'b1, 1'b0, 32'h10, 32'd1);
    next(); drv(1'b1, 1'b0, 32'h14, 32'd2);
    next(); drv(1'b1, 1'b0, 32'h18, 32'd3);
    next(); drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("a_count3", 32'(count), 32'd3);
    chk("a_req", 32'(mem_req), 32'd1);
    chk("a_we", 32'(mem_we), 32'd1);
    chk("a_addr", mem_addr, 32'h10);
    chk("a_wdata", mem_wdata, 32'd1);
    Reset = 1'b1;
    next(); next();
    Reset = 1'b0; #2;
    chk("a_rst_req", 32'(mem_req), 32'd0);
    chk("a_rst_count", 32'(count), 32'd0);
    chk("a_rst_empty", 32'(empty), 32'd1);
    chk("a_rst_stall", 32'(cpu_stall), 32'd0);

    // Fill to full with memory stalled; fifth store stalls.
    for (int i = 0; i < 4; i++) begin
      next(); drv(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      chk("b_fill_stall", 32'(cpu_stall), 32'd0);
    end
    next(); drv(1'b1, 1'b0, 32'h110, 32'hB000_0004);
    chk("b_full_count", 32'(count), 32'd4);
    chk("b_full_stall", 32'(cpu_stall), 32'd1);
    chk("b_head_addr", mem_addr, 32'h100);
    next(); mem_ready = 1'b1; #2;
    chk("b_nobypass_stall", 32'(cpu_stall), 32'd1);
    chk("b_nobypass_count", 32'(count), 32'd4);
    next(); mem_ready = 1'b0; #2;
    chk("b_accept_stall", 32'(cpu_stall), 32'd0);
    chk("b_accept_count", 32'(count), 32'd3);
    chk("b_next_addr", mem_addr, 32'h104);
    chk("b_next_wdata", mem_wdata, 32'hB000_0001);
    next(); mem_ready = 1'b1; drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("b_refull_count", 32'(count), 32'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("b_drain_req", 32'(mem_req), 32'd1);
      chk("b_drain_addr", mem_addr, 32'h100 + 32'(4 * i));
      chk("b_drain_wdata", mem_wdata, 32'hB000_0000 + 32'(i));
      next(); #2;
    end
    chk("b_empty", 32'(empty), 32'd1);
    chk("b_count0", 32'(count), 32'd0);
    chk("b_req0", 32'(mem_req), 32'd0);
    mem_ready = 1'b0;

    // Forwarding from the youngest of two same-address entries.
    next(); drv(1'b1, 1'b0, 32'h200, 32'hAAAA_0000);
    next(); drv(1'b1, 1'b0, 32'h200, 32'hBBBB_1111);
    next(); drv(1'b0, 1'b1, 32'h203, 32'd0);
    chk("c_fwd_data", cpu_rdata, 32'hBBBB_1111);
    chk("c_fwd_stall", 32'(cpu_stall), 32'd0);
    chk("c_drain_we", 32'(mem_we), 32'd1);
    next(); mem_ready = 1'b1; drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("c_noread_we", 32'(mem_we), 32'd1);
    chk("c_drain0", mem_wdata, 32'hAAAA_0000);
    next(); #2;
    chk("c_drain1", mem_wdata, 32'hBBBB_1111);
    chk("c_drain1_addr", mem_addr, 32'h200);
    next(); #2;
    chk("c_empty", 32'(empty), 32'd1);
    mem_ready = 1'b0;

    // Load miss while a drain is in flight.
    next(); drv(1'b1, 1'b0, 32'h300, 32'h33);
    next(); drv(1'b1, 1'b0, 32'h304, 32'h44);
    next(); drv(1'b0, 1'b1, 32'h400, 32'd0);
    chk("d_miss_stall", 32'(cpu_stall), 32'd1);
    chk("d_inflight_addr", mem_addr, 32'h300);
    next(); mem_ready = 1'b1; #2;
    chk("d_wait_stall", 32'(cpu_stall), 32'd1);
    chk("d_wait_we", 32'(mem_we), 32'd1);
    next(); mem_ready = 1'b0; #2;
    chk("d_load_req", 32'(mem_req), 32'd1);
    chk("d_load_we", 32'(mem_we), 32'd0);
    chk("d_load_addr", mem_addr, 32'h400);
    chk("d_load_count", 32'(count), 32'd1);
    chk("d_load_stall", 32'(cpu_stall), 32'd1);
    next(); mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF; #2;
    chk("d_ready_stall", 32'(cpu_stall), 32'd0);
    chk("d_ready_rdata", cpu_rdata, 32'hDEAD_BEEF);
    next(); mem_rdata = 32'd0; drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("d_idle_req", 32'(mem_req), 32'd0);
    next(); #2;
    chk("d_rem_req", 32'(mem_req), 32'd1);
    chk("d_rem_we", 32'(mem_we), 32'd1);
    chk("d_rem_addr", mem_addr, 32'h304);
    chk("d_rem_wdata", mem_wdata, 32'h44);
    next(); #2;
    chk("d_empty", 32'(empty), 32'd1);
    mem_ready = 1'b0;

    // Enqueue and pop in the same cycle.
    next(); drv(1'b1, 1'b0, 32'h500, 32'hA1);
    next(); drv(1'b1, 1'b0, 32'h504, 32'hA2);
    next(); mem_ready = 1'b1; drv(1'b1, 1'b0, 32'h508, 32'hA3);
    chk("f_count_pre", 32'(count), 32'd2);
    chk("f_head", mem_addr, 32'h500);
    next(); drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("f_count_same", 32'(count), 32'd2);
    chk("f_order1_addr", mem_addr, 32'h504);
    chk("f_order1_data", mem_wdata, 32'hA2);
    next(); #2;
    chk("f_order2_addr", mem_addr, 32'h508);
    chk("f_order2_data", mem_wdata, 32'hA3);
    next(); #2;
    chk("f_empty", 32'(empty), 32'd1);

    // Zero-wait back-to-back drain of three stores.
    next(); drv(1'b1, 1'b0, 32'h600, 32'hE0);
    next(); drv(1'b1, 1'b0, 32'h604, 32'hE1);
    next(); drv(1'b1, 1'b0, 32'h608, 32'hE2);
    chk("e_w0_req", 32'(mem_req), 32'd1);
    chk("e_w0_addr", mem_addr, 32'h600);
    next(); drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("e_w1_addr", mem_addr, 32'h604);
    next(); #2;
    chk("e_w2_addr", mem_addr, 32'h608);
    chk("e_w2_data", mem_wdata, 32'hE2);
    next(); #2;
    chk("e_empty", 32'(empty), 32'd1);
    chk("e_req0", 32'(mem_req), 32'd0);

    // Idle load miss with zero-wait memory: one stall cycle.
    next(); mem_rdata = 32'h1234_5678; drv(1'b0, 1'b1, 32'h702, 32'd0);
    chk("g_stall", 32'(cpu_stall), 32'd1);
    chk("g_req_pre", 32'(mem_req), 32'd0);
    next(); #2;
    chk("g_req", 32'(mem_req), 32'd1);
    chk("g_we", 32'(mem_we), 32'd0);
    chk("g_addr", mem_addr, 32'h700);
    chk("g_stall_done", 32'(cpu_stall), 32'd0);
    chk("g_rdata", cpu_rdata, 32'h1234_5678);
    next(); drv(1'b0, 1'b0, 32'd0, 32'd0);
    chk("g_idle_req", 32'(mem_req), 32'd0);
    chk("g_idle_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/store_write_buffer.md
# store_write_buffer

Posted-store write buffer between the CPU's MEM stage and the data-side main memory. Stores retire from the pipeline into a DEPTH-entry FIFO and drain to memory in the background. Loads that hit a buffered address are forwarded from the buffer with zero latency; load misses arbitrate for the single memory port ahead of pending drains. The block owns the only stall source the MEM stage sees for data memory.

## Interface
Parameters:
- DEPTH, 4, number of buffered stores; power of two, ≥2
- CW, $clog2(DEPTH)+1, width of `count`

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high reset
- cpu_we  in  1  MEM-stage store strobe (MemWrite)
- cpu_re  in  1  MEM-stage load strobe (MemtoReg)
- cpu_addr  in  32  byte address from ALU; bits [1:0] ignored, word match on [31:2]
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data to MEM/RB register
- cpu_stall  out  1  hold IF…MEM stages this cycle
- mem_req  out  1  memory request valid (registered)
- mem_we  out  1  1 = write (drain), 0 = read (load miss)
- mem_addr  out  32  word-aligned address, bits [1:0] = 0
- mem_wdata  out  32  write data
- mem_ready  in  1  memory accepts/completes request this cycle
- mem_rdata  in  32  read data, valid when mem_ready & !mem_we
- empty  out  1  no buffered stores and FSM IDLE (fence/halt use)
- count  out  CW  buffered entries, 0..DEPTH

## Operation
- FIFO: head/tail pointers wrap modulo DEPTH; entry = {addr[31:2], data}. Entry stays valid until its drain completes.
- Store: `cpu_we & !full` → enqueue at edge, no stall. `cpu_we & full` → `cpu_stall`=1, no enqueue. Drain completing in the same cycle does not relieve the stall (no full-bypass). `cpu_we` and `cpu_re` both high → treated as store, `cpu_re` ignored.
- Load hit: `cpu_re` with address matching any valid entry (including the head entry being drained) → `cpu_rdata` = data of the youngest matching entry, combinational, `cpu_stall`=0.
- Load miss: `cpu_stall`=1 until read data returns. Memory read takes priority over starting a new drain. It never pre-empts a drain already in flight.
- Merging: none. Duplicate addresses occupy separate entries and drain in order.
- FSM states:
  - IDLE
    - load miss → LOAD
    - else count>0 → DRAIN
    - else stay
  - DRAIN: `mem_req`=1, `mem_we`=1, addr/data = head. On `mem_ready`, pop head, then:
    - load miss pending → LOAD
    - else entries remain after pop → DRAIN on the next head, back-to-back
    - else IDLE
  - LOAD: `mem_req`=1, `mem_we`=0, `mem_addr` = latched miss address. On `mem_ready`: `cpu_rdata`=`mem_rdata` and `cpu_stall`=0 that cycle, then go to IDLE.
- Request stability: `mem_addr`, `mem_wdata`, `mem_we` held constant while `mem_req`=1 until the `mem_ready` edge. `mem_ready` is ignored when `mem_req`=0.
- Enqueue and pop in the same cycle → count unchanged, both pointers advance.
- Reset (any state, including mid-request):
  - pointers and count → 0; FSM → IDLE
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_rdata`, `cpu_stall` → 0; `empty` → 1
  - in-flight request and buffered stores are discarded

## Timing
- Store accept: 0 stall cycles when not full; visible in `count` the next cycle.
- Load hit: 0 cycles, combinational from cpu_addr.
- Load miss, buffer idle:
  - cycle N: miss seen, stall
  - cycle N+1: `mem_req` rises
  - total stall cycles = 1 + memory wait states; zero-wait memory gives exactly 1 stall cycle
- Load miss during drain: additionally waits for the in-flight drain's `mem_ready`, then goes directly to LOAD (no IDLE cycle).
- Drain throughput with zero-wait memory: one store per cycle after a 1-cycle IDLE→DRAIN start.
- `cpu_stall` is combinational from FSM state, `cpu_we/cpu_re`, `full`, hit logic and `mem_ready`. It must not depend on `cpu_wdata`.

## Test plan
- **Reset:** Reset held 2 cycles mid-DRAIN with count=3 → next cycle `mem_req`=0, `count`=0, `empty`=1, `cpu_stall`=0.
- **Fill/full stall:** `mem_ready` tied 0, five stores to 0x100,0x104,0x108,0x10C,0x110 (DEPTH=4) → first four accepted, `count`=4, fifth stalls. Raise `mem_ready` 1 cycle → 0x100 drained. Fifth store accepted the following cycle.
- **Forwarding:** stores 0x200←0xAAAA0000 then 0x200←0xBBBB1111 (memory stalled), load 0x203 → `cpu_rdata`=0xBBBB1111 same cycle, `cpu_stall`=0, no read request.
- **Load miss priority:** count=2 with a drain in flight, load 0x400, memory returns 0xDEADBEEF → drain completes first, then read of 0x400. `cpu_rdata`=0xDEADBEEF on the ready cycle. Remaining store drains afterwards.
- **Zero-wait back-to-back drain:** `mem_ready`=1 constantly, 3 stores → three consecutive write requests in order, `empty`=1 the cycle after the third.
- **Simultaneous enqueue/pop:** count=2, store arrives in the same cycle as drain `mem_ready` → `count` stays 2, order preserved.
